// File: rtl/sysid_probe_pkg.sv
// Shared definitions for the sysid probe controller: the FSM state type,
// the two word addresses of the sysid slave and a counter-width helper.
package sysid_probe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WT_ID,
        RD_TS,
        WT_TS,
        CHECK,
        FIN
    } probe_state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Bits needed to hold values 0..maxVal, never less than one bit.
    function automatic int unsigned cntWidth(input int unsigned maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/sysid_probe_ctrl_if.sv
// Avalon-MM read-only master bus between the probe controller and the
// sysid slave.
interface sysid_probe_ctrl_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdatavalid,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdatavalid,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_probe_timer.sv
// Response timeout counter: clear restarts it at zero, enable advances it,
// and expired_o flags that LIMIT cycles have passed. It parks at LIMIT.
module sysid_probe_timer #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned WIDTH = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             expired;

    assign expired   = (count_q == WIDTH'(LIMIT));
    assign expired_o = expired;

    // Next count: clear wins, otherwise step while enabled and not yet expired.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, zeroed by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sysid_probe_ctrl.sv
// Sysid probe controller: reads the ID and timestamp words from a sysid
// slave, compares them with the expected values and reports the outcome.
// Unanswered reads are retried a bounded number of times before giving up.
module sysid_probe_ctrl
    import sysid_probe_pkg::*;
#(
    parameter logic [31:0] EXP_ID     = 32'h0000_0000,
    parameter logic [31:0] EXP_TS     = 32'd1477164153,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_RETRY  = 3,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    sysid_probe_ctrl_if.master avm,
    output logic               busy,
    output logic               done,
    output logic               id_ok,
    output logic               ts_ok,
    output logic               timeout_err,
    output logic [31:0]        id_value,
    output logic [31:0]        ts_value
);

    localparam int unsigned TW = cntWidth(TIMEOUT);
    localparam int unsigned RW = cntWidth(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    probe_state_e  state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          autoPending_q;
    logic          done_q, done_d;
    logic          idOk_q, idOk_d;
    logic          tsOk_q, tsOk_d;
    logic          timeoutErr_q, timeoutErr_d;
    logic [31:0]   idValue_q, idValue_d;
    logic [31:0]   tsValue_q, tsValue_d;

    logic timerClear;
    logic timerEnable;
    logic timerExpired;
    logic waitExpired;
    logic avmRead;
    logic avmAddress;
    logic busyComb;

    sysid_probe_timer #(
        .LIMIT (TIMEOUT),
        .WIDTH (TW)
    ) timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (timerClear),
        .enable_i  (timerEnable),
        .expired_o (timerExpired)
    );

    // Sequencer: next state, bus strobes, captures and result flags.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        done_d       = done_q;
        idOk_d       = idOk_q;
        tsOk_d       = tsOk_q;
        timeoutErr_d = timeoutErr_q;
        idValue_d    = idValue_q;
        tsValue_d    = tsValue_q;
        timerClear   = 1'b0;
        timerEnable  = 1'b0;
        waitExpired  = 1'b0;
        avmRead      = 1'b0;
        avmAddress   = ADDR_ID;
        busyComb     = 1'b1;

        case (state_q)
            IDLE: begin
                busyComb = 1'b0;
                if (start || autoPending_q) begin
                    done_d       = 1'b0;
                    idOk_d       = 1'b0;
                    tsOk_d       = 1'b0;
                    timeoutErr_d = 1'b0;
                    retry_d      = '0;
                    state_d      = RD_ID;
                end
            end
            RD_ID: begin
                avmRead    = 1'b1;
                avmAddress = ADDR_ID;
                if (!avm.avm_waitrequest) begin
                    timerClear = 1'b1;
                    state_d    = WT_ID;
                end
            end
            WT_ID: begin
                avmAddress = ADDR_ID;
                if (avm.avm_readdatavalid) begin
                    idValue_d = avm.avm_readdata;
                    state_d   = RD_TS;
                end else if (timerExpired) begin
                    waitExpired = 1'b1;
                end else begin
                    timerEnable = 1'b1;
                end
            end
            RD_TS: begin
                avmRead    = 1'b1;
                avmAddress = ADDR_TS;
                if (!avm.avm_waitrequest) begin
                    timerClear = 1'b1;
                    state_d    = WT_TS;
                end
            end
            WT_TS: begin
                avmAddress = ADDR_TS;
                if (avm.avm_readdatavalid) begin
                    tsValue_d = avm.avm_readdata;
                    state_d   = CHECK;
                end else if (timerExpired) begin
                    waitExpired = 1'b1;
                end else begin
                    timerEnable = 1'b1;
                end
            end
            CHECK: begin
                idOk_d  = (idValue_q == EXP_ID);
                tsOk_d  = (tsValue_q == EXP_TS);
                done_d  = 1'b1;
                state_d = FIN;
            end
            FIN: begin
                busyComb = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                busyComb = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // A silent slave restarts the whole sequence until retries run out.
        if (waitExpired) begin
            if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + RW'(1);
                state_d = RD_ID;
            end else begin
                timeoutErr_d = 1'b1;
                idOk_d       = 1'b0;
                tsOk_d       = 1'b0;
                done_d       = 1'b1;
                state_d      = FIN;
            end
        end
    end

    // State and result registers; the auto-start request lives for one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            retry_q       <= '0;
            autoPending_q <= AUTO_START;
            done_q        <= 1'b0;
            idOk_q        <= 1'b0;
            tsOk_q        <= 1'b0;
            timeoutErr_q  <= 1'b0;
            idValue_q     <= '0;
            tsValue_q     <= '0;
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            autoPending_q <= 1'b0;
            done_q        <= done_d;
            idOk_q        <= idOk_d;
            tsOk_q        <= tsOk_d;
            timeoutErr_q  <= timeoutErr_d;
            idValue_q     <= idValue_d;
            tsValue_q     <= tsValue_d;
        end
    end

    assign avm.avm_read    = avmRead;
    assign avm.avm_address = avmAddress;
    assign busy            = busyComb;
    assign done            = done_q;
    assign id_ok           = idOk_q;
    assign ts_ok           = tsOk_q;
    assign timeout_err     = timeoutErr_q;
    assign id_value        = idValue_q;
    assign ts_value        = tsValue_q;

endmodule

// File: tb/tb_sysid_probe_ctrl.sv
// Scoreboard bench for sysid_probe_ctrl: a configurable sysid slave model,
// a sequence-level reference model feeding an expectation queue, and a
// monitor that checks every completed sequence.
module tb_sysid_probe_ctrl;

    localparam logic [31:0] EXP_ID    = 32'h0000_0000;
    localparam logic [31:0] EXP_TS    = 32'd1477164153;
    localparam int          TIMEOUT   = 4;
    localparam int          MAX_RETRY = 1;

    typedef struct {
        logic        idOk;
        logic        tsOk;
        logic        tmo;
        logic [31:0] idVal;
        logic [31:0] tsVal;
        int          doneCycle;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    // Slave behaviour knobs (delay 0 = never answers).
    int          cfgStall = 0;
    int          cfgIdDelay = 1;
    int          cfgTsDelay = 1;
    logic [31:0] cfgIdData = EXP_ID;
    logic [31:0] cfgTsData = EXP_TS;
    bit          cfgSpurious = 1'b0;
    bit          cfgBusyStart = 1'b0;

    // Slave internal state and acceptance counters.
    int          respCnt = 0;
    logic [31:0] respData = '0;
    bit          readActive = 1'b0;
    int          stallLeft = 0;
    logic        heldAddr = 1'b0;
    int          acceptId = 0;
    int          acceptTs = 0;

    // Reference model state: words the controller should be holding.
    logic [31:0] mdlIdVal = '0;
    logic [31:0] mdlTsVal = '0;
    exp_t        sbq[$];
    exp_t        monExp;
    bit          donePrev = 1'b0;

    sysid_probe_ctrl_if avm();

    sysid_probe_ctrl #(
        .EXP_ID     (EXP_ID),
        .EXP_TS     (EXP_TS),
        .TIMEOUT    (TIMEOUT),
        .MAX_RETRY  (MAX_RETRY),
        .AUTO_START (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .avm         (avm),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout_err (timeout_err),
        .id_value    (id_value),
        .ts_value    (ts_value)
    );

    always #5 clock = ~clock;

    // Free-running edge counter used to time sequence completion.
    always @(posedge clock) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
        end
    endtask

    // Outcome of one sequence from the slave behaviour: each read costs its
    // stall plus acceptance cycle, then either its response delay or a full
    // timeout window; a failed read restarts the sequence until retries run out.
    function automatic exp_t predict(input int startCycle);
        exp_t e;
        int   cyc;
        int   dly;
        bit   ok;
        cyc   = 1;
        e.tmo = 1'b1;
        for (int a = 0; a <= MAX_RETRY && e.tmo; a++) begin
            ok = 1'b1;
            for (int r = 0; r < 2 && ok; r++) begin
                dly = (r == 0) ? cfgIdDelay : cfgTsDelay;
                cyc += cfgStall + 1;
                if (dly >= 1 && dly <= TIMEOUT + 1) begin
                    cyc += dly;
                    if (r == 0) mdlIdVal = cfgIdData;
                    else        mdlTsVal = cfgTsData;
                end else begin
                    cyc += TIMEOUT + 1;
                    ok = 1'b0;
                end
            end
            if (ok) begin
                e.tmo = 1'b0;
                cyc += 1;
            end
        end
        e.idOk      = !e.tmo && (mdlIdVal == EXP_ID);
        e.tsOk      = !e.tmo && (mdlTsVal == EXP_TS);
        e.idVal     = mdlIdVal;
        e.tsVal     = mdlTsVal;
        e.doneCycle = startCycle + cyc - 1;
        return e;
    endfunction

    // Sysid slave: stalls each read, answers after the configured delay,
    // injects stray readdatavalid where the controller must ignore it, and
    // checks that a stalled read is held stable.
    always @(negedge clock) begin
        if (!reset_n) begin
            respCnt                = 0;
            readActive             = 1'b0;
            avm.avm_waitrequest    = 1'b0;
            avm.avm_readdatavalid  = 1'b0;
        end else begin
            avm.avm_readdatavalid = 1'b0;
            if (respCnt > 0) begin
                if (respCnt == 1) begin
                    avm.avm_readdatavalid = 1'b1;
                    avm.avm_readdata      = respData;
                end
                respCnt--;
            end else if (cfgSpurious && (avm.avm_read || !busy) && $urandom_range(3) == 0) begin
                avm.avm_readdatavalid = 1'b1;
                avm.avm_readdata      = $urandom();
            end

            avm.avm_waitrequest = 1'b0;
            if (readActive) begin
                checks++;
                if (!avm.avm_read || avm.avm_address !== heldAddr) begin
                    errors++;
                    $display("[TB] FAIL stalled_read_stable: actual read=%0b addr=%0b required read=1 addr=%0b",
                             avm.avm_read, avm.avm_address, heldAddr);
                end
            end
            if (avm.avm_read) begin
                if (!readActive) begin
                    readActive = 1'b1;
                    heldAddr   = avm.avm_address;
                    stallLeft  = cfgStall;
                end
                if (stallLeft > 0) begin
                    avm.avm_waitrequest = 1'b1;
                    stallLeft--;
                end else begin
                    readActive = 1'b0;
                    if (heldAddr) begin
                        acceptTs++;
                        respCnt  = cfgTsDelay;
                        respData = cfgTsData;
                    end else begin
                        acceptId++;
                        respCnt  = cfgIdDelay;
                        respData = cfgIdData;
                    end
                end
            end else begin
                readActive = 1'b0;
            end
        end
    end

    // Monitor: every rising done is matched against the oldest expectation.
    always @(negedge clock) begin
        if (!reset_n) begin
            donePrev = 1'b0;
        end else begin
            if (done && !donePrev) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: actual done=1 required no sequence pending");
                end else begin
                    monExp = sbq.pop_front();
                    checkOutput("id_ok", id_ok, monExp.idOk);
                    checkOutput("ts_ok", ts_ok, monExp.tsOk);
                    checkOutput("timeout_err", timeout_err, monExp.tmo);
                    checkOutput("id_value", id_value, monExp.idVal);
                    checkOutput("ts_value", ts_value, monExp.tsVal);
                    checkOutput("done_cycle", cycleCount, monExp.doneCycle);
                    checkOutput("busy_at_fin", busy, 1'b0);
                end
            end
            donePrev = done;
        end
    end

    task automatic applyStimulus();
        @(negedge clock);
        sbq.push_back(predict(cycleCount + 1));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            start = cfgBusyStart && busy && ($urandom_range(7) == 0);
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sequence_wait: actual pending=%0d required pending=0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic setSlave(input int stall, input int idDly, input int tsDly,
                            input logic [31:0] idData, input logic [31:0] tsData);
        cfgStall   = stall;
        cfgIdDelay = idDly;
        cfgTsDelay = tsDly;
        cfgIdData  = idData;
        cfgTsData  = tsData;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_avm_read"}, avm.avm_read, 1'b0);
        checkOutput({tag, "_avm_address"}, avm.avm_address, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_id_ok"}, id_ok, 1'b0);
        checkOutput({tag, "_ts_ok"}, ts_ok, 1'b0);
        checkOutput({tag, "_timeout_err"}, timeout_err, 1'b0);
        checkOutput({tag, "_id_value"}, id_value, 32'h0);
        checkOutput({tag, "_ts_value"}, ts_value, 32'h0);
    endtask

    // Abort whatever is running and drop its expectation.
    task automatic enterReset();
        reset_n = 1'b0;
        sbq.delete();
        mdlIdVal = '0;
        mdlTsVal = '0;
    endtask

    // Release reset on a falling edge; the auto-start sequence is expected.
    task automatic releaseReset();
        @(negedge clock);
        sbq.push_back(predict(cycleCount + 1));
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        avm.avm_waitrequest   = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        avm.avm_readdata      = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checkResetOutputs("reset");

        // Auto-start against the default slave, then no second auto-start.
        setSlave(0, 1, 1, EXP_ID, EXP_TS);
        releaseReset();
        waitIdle(100);
        repeat (20) @(negedge clock);
        checkOutput("single_autostart_busy", busy, 1'b0);
        checkOutput("sticky_done", done, 1'b1);

        // Wrong ID word.
        setSlave(0, 1, 1, 32'h0000_0001, EXP_TS);
        applyStimulus();
        waitIdle(100);

        // Five stall cycles on each read.
        setSlave(5, 1, 1, EXP_ID, EXP_TS);
        applyStimulus();
        waitIdle(100);

        // Silent slave: one retry, then give up.
        setSlave(0, 0, 0, EXP_ID, EXP_TS);
        acceptId = 0;
        acceptTs = 0;
        applyStimulus();
        waitIdle(200);
        checkOutput("silent_id_accepts", acceptId, MAX_RETRY + 1);
        checkOutput("silent_ts_accepts", acceptTs, 0);

        // Responses exactly on the timeout cycle are still taken.
        setSlave(0, TIMEOUT + 1, TIMEOUT + 1, EXP_ID, EXP_TS);
        applyStimulus();
        waitIdle(100);

        // Timestamp one cycle too late on every attempt.
        setSlave(1, 2, TIMEOUT + 2, 32'h1234_5678, EXP_TS);
        applyStimulus();
        waitIdle(200);

        // A start in the FIN cycle is ignored.
        setSlave(0, 1, 1, EXP_ID, EXP_TS);
        applyStimulus();
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("fin_cycle_reached", done, 1'b1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("fin_start_busy", busy, 1'b0);
        repeat (5) @(negedge clock);
        checkOutput("fin_start_busy_later", busy, 1'b0);
        checkOutput("fin_start_done", done, 1'b1);
        waitIdle(10);

        // Start while busy, then reset during the timestamp wait.
        setSlave(0, 1, 0, 32'hA5A5_0001 | ($urandom() << 1), EXP_TS);
        applyStimulus();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checkOutput("busy_start_ignored", busy, 1'b1);
        checkOutput("pre_reset_id_value", id_value, cfgIdData);
        repeat (2) @(negedge clock);
        enterReset();
        #1;
        checkResetOutputs("midseq_reset");
        repeat (2) @(negedge clock);
        setSlave(0, 1, 1, EXP_ID, EXP_TS);
        releaseReset();
        waitIdle(100);

        // Reset while a read is being stalled drops avm_read at once.
        setSlave(10, 1, 1, EXP_ID, EXP_TS);
        applyStimulus();
        checkOutput("stalled_read_active", avm.avm_read, 1'b1);
        enterReset();
        #1;
        checkOutput("async_read_drop", avm.avm_read, 1'b0);
        checkOutput("async_busy_drop", busy, 1'b0);
        repeat (2) @(negedge clock);
        setSlave(0, 1, 1, EXP_ID, EXP_TS);
        releaseReset();
        waitIdle(100);

        // Randomised sequences with stray responses and busy-time starts.
        cfgSpurious  = 1'b1;
        cfgBusyStart = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int pick;
            cfgStall = $urandom_range(3);
            pick = $urandom_range(9);
            cfgIdDelay = (pick == 0) ? 0 : (pick == 1) ? TIMEOUT + 2 : $urandom_range(TIMEOUT + 1, 1);
            pick = $urandom_range(9);
            cfgTsDelay = (pick == 0) ? 0 : (pick == 1) ? TIMEOUT + 2 : $urandom_range(TIMEOUT + 1, 1);
            cfgIdData = ($urandom_range(1) == 0) ? EXP_ID : $urandom();
            cfgTsData = ($urandom_range(1) == 0) ? EXP_TS : $urandom();
            applyStimulus();
            waitIdle(200);
            repeat ($urandom_range(3)) @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual time limit reached required finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sysid_probe_ctrl.md
SYSID_PROBE_CTRL -- requirements
Module: sysid_probe_ctrl

Interface
REQ-001 Parameter EXP_ID, default 32'h0000_0000, expected system ID word (address 0).
REQ-002 Parameter EXP_TS, default 32'd1477164153, expected timestamp word (address 1).
REQ-003 Parameter TIMEOUT, default 255, maximum cycles from read acceptance to readdatavalid.
REQ-004 Parameter MAX_RETRY, default 3, number of sequence retries after a timeout.
REQ-005 Parameter AUTO_START, default 1; when 1, the block starts one sequence on the first cycle after reset release.
REQ-006 Port clock, input, 1, the only clock; all logic is rising-edge.
REQ-007 Port reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port start, input, 1, single-cycle request to run a check sequence.
REQ-009 Port avm_address, output, 1, word address to the sysid slave.
REQ-010 Port avm_read, output, 1, read strobe.
REQ-011 Port avm_waitrequest, input, 1, slave stall.
REQ-012 Port avm_readdatavalid, input, 1, read data valid.
REQ-013 Port avm_readdata, input, 32, read data.
REQ-014 Port busy, output, 1, sequence in progress.
REQ-015 Port done, output, 1, sticky completion flag.
REQ-016 Port id_ok, output, 1, captured ID equals EXP_ID.
REQ-017 Port ts_ok, output, 1, captured timestamp equals EXP_TS.
REQ-018 Port timeout_err, output, 1, retries exhausted without a response.
REQ-019 Ports id_value and ts_value, output, 32 each, last captured words.

Function
REQ-020 FSM states: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, FIN.
REQ-021 IDLE->RD_ID on start or the auto-start event; done, id_ok, ts_ok and timeout_err clear on that transition.
REQ-022 In RD_ID: avm_read=1 and avm_address=0, held stable until a cycle with avm_waitrequest=0, then ->WT_ID.
REQ-023 In WT_ID: avm_read=0; on avm_readdatavalid, id_value<=avm_readdata, then ->RD_TS.
REQ-024 RD_TS and WT_TS behave as RD_ID and WT_ID, with avm_address=1 and capture into ts_value; WT_TS->CHECK.
REQ-025 CHECK: one cycle; id_ok and ts_ok register the 32-bit equality results; ->FIN.
REQ-026 FIN: done=1, busy=0; ->IDLE the same cycle; flags hold until the next start.
REQ-027 busy=1 in every state except IDLE and FIN.
REQ-028 The timeout counter loads 0 on entry to WT_ID or WT_TS and increments each cycle without readdatavalid.
REQ-029 If the counter reaches TIMEOUT, the retry counter increments and the FSM returns to RD_ID.
REQ-030 After MAX_RETRY retries and a further timeout, timeout_err=1, id_ok=0, ts_ok=0, and the FSM goes ->FIN.
REQ-031 start while busy is ignored; start in the FIN cycle is ignored.
REQ-032 readdatavalid outside WT_ID or WT_TS is ignored.
REQ-033 readdatavalid on the same cycle the counter reaches TIMEOUT counts as a valid response, and no retry occurs.
REQ-034 Minimum sequence latency, with zero waitrequest and one-cycle readdatavalid: start to done is 6 cycles.

Reset
REQ-035 While reset_n=0, all state returns to IDLE; all outputs are 0, including id_value and ts_value; counters are 0.
REQ-036 Reset asserted mid-sequence aborts immediately, with avm_read deasserting asynchronously.
REQ-037 The auto-start event fires exactly once per reset release.

Structure
REQ-038 Package sysid_probe_pkg holds the FSM state enum, ADDR_ID=1'b0 and ADDR_TS=1'b1.
REQ-039 One sub-module, sysid_probe_timer, implements the clear/enable/expire timeout counter; the retry counter stays in the top level.

Verification
REQ-040 Default slave (addr0=0, addr1=1477164153), auto-start, no stalls -> done=1, id_ok=1, ts_ok=1, 6 cycles after reset release.
REQ-041 Slave returns 32'h0000_0001 at addr0 -> done=1, id_ok=0, ts_ok=1, id_value=1.
REQ-042 waitrequest held 5 cycles on each read -> avm_address and avm_read stay stable throughout; result as in REQ-040, done at cycle 16.
REQ-043 Slave never asserts readdatavalid, TIMEOUT=4, MAX_RETRY=1 -> exactly 2 read acceptances at addr0, then timeout_err=1, done=1.
REQ-044 start pulsed while busy, then reset_n pulled low mid WT_TS -> start is ignored; on reset, all outputs are 0 and avm_read is 0 immediately.
REQ-045 readdatavalid on the exact TIMEOUT cycle -> data is captured, no retry occurs, and the sequence completes with ok flags.
